// File: rtl/bcd_inc_sequencer.sv
// Digit-serial BCD +1 sequencer: one digit per clock, LSD first, stops when carry dies.
// Optional build macro BCD_SATURATE_EN: on overflow, hold all-9s instead of wrapping to zero.
module bcd_inc_sequencer #(
    parameter int NDIG = 3,
    parameter int IDXW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [4*NDIG-1:0] din,
    output logic              done_valid,
    input  logic              done_ready,
    output logic [4*NDIG-1:0] dout,
    output logic              overflow,
    output logic              invalid,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [4*NDIG-1:0]   r_work;
    logic [IDXW-1:0]     r_idx;
    logic [4*NDIG-1:0]   r_dout;
    logic                r_overflow;
    logic                r_invalid;

    logic                w_accept;
    logic                w_din_invalid;
    logic [3:0]          w_digit;
    logic [3:0]          w_digit_inc;
    logic                w_digit_is9;
    logic                w_last_idx;
    logic [4*NDIG-1:0]   w_work_upd;
    logic [4*NDIG-1:0]   w_ovf_value;

`ifdef BCD_SATURATE_EN
    // Overflow only occurs for an all-9s operand, so holding the input is the same as all 9s.
    assign w_ovf_value = {NDIG{4'h9}};
`else
    assign w_ovf_value = '0;
`endif

    assign start_ready = (r_state == S_IDLE) && !rst;
    assign done_valid  = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE);
    assign dout        = r_dout;
    assign overflow    = r_overflow;
    assign invalid     = r_invalid;

    assign w_accept    = start_valid && start_ready;

    always_comb begin
        w_din_invalid = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (din[4*i +: 4] > 4'd9) begin
                w_din_invalid = 1'b1;
            end
        end
    end

    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_digit = r_work[4*i +: 4];
            end
        end
    end

    // Carry is implicitly 1 for every RUN cycle; RUN is left as soon as it dies.
    assign w_digit_is9 = (w_digit == 4'd9);
    assign w_digit_inc = w_digit_is9 ? 4'd0 : (w_digit + 4'd1);
    assign w_last_idx  = (r_idx == IDXW'(NDIG - 1));

    always_comb begin
        w_work_upd = r_work;
        for (int i = 0; i < NDIG; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_work_upd[4*i +: 4] = w_digit_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_din_invalid ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (!w_digit_is9 || w_last_idx) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (done_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work     <= '0;
            r_idx      <= '0;
            r_dout     <= '0;
            r_overflow <= 1'b0;
            r_invalid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_work     <= din;
                        r_idx      <= '0;
                        r_overflow <= 1'b0;
                        r_invalid  <= 1'b0;
                        if (w_din_invalid) begin
                            r_dout    <= din;
                            r_invalid <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_work <= w_work_upd;
                    r_idx  <= r_idx + 1'b1;
                    if (!w_digit_is9) begin
                        r_dout <= w_work_upd;
                    end else if (w_last_idx) begin
                        r_dout     <= w_ovf_value;
                        r_overflow <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_inc_sequencer.sv
// Directed self-checking bench for bcd_inc_sequencer (NDIG=3), checked with immediate assertions.
module tb_bcd_inc_sequencer;

    logic        clk;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [11:0] din;
    logic        done_valid;
    logic        done_ready;
    logic [11:0] dout;
    logic        overflow;
    logic        invalid;
    logic        busy;

    int          n_vec;
    int          n_fail;
    logic [11:0] prev_q;

    bcd_inc_sequencer #(.NDIG(3), .IDXW(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .din         (din),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .dout        (dout),
        .overflow    (overflow),
        .invalid     (invalid),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accepts d, waits for done_valid, checks latency and result; leaves block in DONE.
    task automatic run_op(input logic [11:0] d, input logic [11:0] exp_q,
                          input logic exp_ovf, input logic exp_inv, input int exp_lat);
        int lat;
        chk("start_ready_idle", {31'd0, start_ready}, 32'd1);
        din         = d;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        din         = 12'hFFF;
        lat         = 0;
        while (!done_valid && lat < 16) begin
            chk("start_ready_run", {31'd0, start_ready}, 32'd0);
            chk("dout_hold_run", {20'd0, dout}, {20'd0, prev_q});
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("dout", {20'd0, dout}, {20'd0, exp_q});
        chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
        chk("invalid", {31'd0, invalid}, {31'd0, exp_inv});
        chk("busy_done", {31'd0, busy}, 32'd1);
        chk("start_ready_done", {31'd0, start_ready}, 32'd0);
        prev_q = exp_q;
    endtask

    task automatic release_done();
        done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
        chk("done_valid_drop", {31'd0, done_valid}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("start_ready_back", {31'd0, start_ready}, 32'd1);
        chk("dout_hold_idle", {20'd0, dout}, {20'd0, prev_q});
    endtask

    initial begin
        n_vec       = 0;
        n_fail      = 0;
        prev_q      = 12'h000;
        rst         = 1'b1;
        start_valid = 1'b0;
        din         = 12'h000;
        done_ready  = 1'b0;

        #1;
        chk("rst_dout", {20'd0, dout}, 32'd0);
        chk("rst_done_valid", {31'd0, done_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_invalid", {31'd0, invalid}, 32'd0);
        chk("rst_start_ready", {31'd0, start_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(12'h123, 12'h124, 1'b0, 1'b0, 1);
        release_done();
        run_op(12'h199, 12'h200, 1'b0, 1'b0, 3);
        release_done();
`ifdef BCD_SATURATE_EN
        run_op(12'h999, 12'h999, 1'b1, 1'b0, 3);
`else
        run_op(12'h999, 12'h000, 1'b1, 1'b0, 3);
`endif
        release_done();
        run_op(12'h1A3, 12'h1A3, 1'b0, 1'b1, 0);
        release_done();
        run_op(12'h989, 12'h990, 1'b0, 1'b0, 2);
        release_done();
        run_op(12'h0F0, 12'h0F0, 1'b0, 1'b1, 0);
        release_done();

        // DONE must hold while done_ready is low and ignore new requests.
        run_op(12'h009, 12'h010, 1'b0, 1'b0, 2);
        start_valid = 1'b1;
        din         = 12'h555;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_done_valid", {31'd0, done_valid}, 32'd1);
            chk("stall_dout", {20'd0, dout}, 32'h010);
            chk("stall_start_ready", {31'd0, start_ready}, 32'd0);
        end
        done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
        chk("stall_release_idle", {31'd0, busy}, 32'd0);
        chk("stall_release_ready", {31'd0, start_ready}, 32'd1);
        @(posedge clk); #1;
        start_valid = 1'b0;
        din         = 12'h000;
        chk("reaccept_busy", {31'd0, busy}, 32'd1);
        chk("reaccept_hold", {20'd0, dout}, 32'h010);
        @(posedge clk); #1;
        chk("reaccept_done", {31'd0, done_valid}, 32'd1);
        chk("reaccept_dout", {20'd0, dout}, 32'h556);
        prev_q = 12'h556;
        release_done();

        // Reset in the middle of a RUN discards the operation.
        din         = 12'h999;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_run_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_dout", {20'd0, dout}, 32'd0);
        chk("mid_rst_done_valid", {31'd0, done_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, start_ready}, 32'd1);
        @(posedge clk); #1;
        prev_q = 12'h000;
        run_op(12'h000, 12'h001, 1'b0, 1'b0, 1);
        release_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
